// File: rtl/udma_l2_resp_pkg.sv
// Shared types and constants for the uDMA L2 responder.
package udma_l2_resp_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } l2_resp_state_e;

  typedef enum logic {
    PORT_RO,
    PORT_WO
  } l2_resp_port_e;

  // Fibonacci LFSR, taps 16,14,13,11 -> state bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/udma_l2_resp_bank.sv
// Single-port byte-enabled memory bank with a 1-cycle registered read.
module udma_l2_resp_bank
  import udma_l2_resp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 4096,
  localparam int unsigned AW        = $clog2(MEM_WORDS)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    we,
  input  logic [AW-1:0]           addr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Byte-masked write; contents are never reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int unsigned k = 0; k < DATA_WIDTH/8; k++) begin
        if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // Read register only updates on a read, so it holds between responses.
  always_ff @(posedge clk) begin
    if (!rstn) rdata <= '0;
    else if (en && !we) rdata <= mem[addr];
  end

endmodule

// File: rtl/udma_l2_responder.sv
// L2 responder for the uDMA RO (read) and WO (write) master ports.
// Round-robin arbitration, programmable wait states, response 1 cycle
// after grant. Optional random grant stalls: define UDMA_L2_RESP_STALL_EN.
module udma_l2_responder
  import udma_l2_resp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_WORDS   = 4096,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                    sys_clk_i,
  input  logic                    rstn_i,
  input  logic                    ro_req_i,
  input  logic                    ro_wen_i,
  input  logic [31:0]             ro_addr_i,
  input  logic [DATA_WIDTH/8-1:0] ro_be_i,
  input  logic [DATA_WIDTH-1:0]   ro_wdata_i,
  output logic                    ro_gnt_o,
  output logic                    ro_rvalid_o,
  output logic [DATA_WIDTH-1:0]   ro_rdata_o,
  input  logic                    wo_req_i,
  input  logic                    wo_wen_i,
  input  logic [31:0]             wo_addr_i,
  input  logic [DATA_WIDTH/8-1:0] wo_be_i,
  input  logic [DATA_WIDTH-1:0]   wo_wdata_i,
  output logic                    wo_gnt_o,
  output logic                    wo_rvalid_o,
  output logic [DATA_WIDTH-1:0]   wo_rdata_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  l2_resp_state_e state, state_n;
  l2_resp_port_e  winner, winner_n, last, last_n, pick;
  logic [3:0]     cnt, cnt_n;
  logic           gnt_ro, gnt_wo, win_req, stall;

  logic unused_ok;
  assign unused_ok = ^{ro_wen_i, ro_be_i, ro_wdata_i, wo_wen_i,
                       ro_addr_i[31:AW+2], ro_addr_i[1:0],
                       wo_addr_i[31:AW+2], wo_addr_i[1:0]};

`ifdef UDMA_L2_RESP_STALL_EN
  logic [15:0] lfsr;

  // Free-running stall generator.
  always_ff @(posedge sys_clk_i) begin
    if (!rstn_i) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // State, latched winner, wait counter and round-robin history.
  always_ff @(posedge sys_clk_i) begin
    if (!rstn_i) begin
      state  <= IDLE;
      winner <= PORT_RO;
      last   <= PORT_WO;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      winner <= winner_n;
      last   <= last_n;
      cnt    <= cnt_n;
    end
  end

  // Arbitration, wait-state sequencing and grant generation.
  always_comb begin
    state_n  = state;
    winner_n = winner;
    cnt_n    = cnt;
    gnt_ro   = 1'b0;
    gnt_wo   = 1'b0;
    if (ro_req_i && wo_req_i) pick = (last == PORT_WO) ? PORT_RO : PORT_WO;
    else if (wo_req_i)        pick = PORT_WO;
    else                      pick = PORT_RO;
    win_req = (winner == PORT_RO) ? ro_req_i : wo_req_i;
    case (state)
      IDLE: begin
        if ((ro_req_i || wo_req_i) && !stall) begin
          if (WAIT_CYCLES == 0) begin
            gnt_ro = (pick == PORT_RO);
            gnt_wo = (pick == PORT_WO);
          end else begin
            winner_n = pick;
            cnt_n    = 4'(WAIT_CYCLES);
            state_n  = WAIT;
          end
        end
      end
      WAIT: begin
        if (!win_req) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt > 4'd1) begin
          cnt_n = cnt - 4'd1;
        end else begin
          // Counter parks at 0 while stalled; grant on the first free cycle.
          cnt_n = '0;
          if (!stall) begin
            gnt_ro  = (winner == PORT_RO);
            gnt_wo  = (winner == PORT_WO);
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // No grant or access while reset is asserted.
    gnt_ro = gnt_ro & rstn_i;
    gnt_wo = gnt_wo & rstn_i;
    last_n = last;
    if (gnt_ro) last_n = PORT_RO;
    if (gnt_wo) last_n = PORT_WO;
  end

  // Responses follow their grant by exactly one cycle.
  always_ff @(posedge sys_clk_i) begin
    if (!rstn_i) begin
      ro_rvalid_o <= 1'b0;
      wo_rvalid_o <= 1'b0;
    end else begin
      ro_rvalid_o <= gnt_ro;
      wo_rvalid_o <= gnt_wo;
    end
  end

  assign ro_gnt_o   = gnt_ro;
  assign wo_gnt_o   = gnt_wo;
  assign wo_rdata_o = '0;

  udma_l2_resp_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_WORDS (MEM_WORDS)
  ) i_bank (
    .clk  (sys_clk_i),
    .rstn (rstn_i),
    .en   (gnt_ro | gnt_wo),
    .we   (gnt_wo),
    .addr (gnt_wo ? wo_addr_i[AW+1:2] : ro_addr_i[AW+1:2]),
    .be   (wo_be_i),
    .wdata(wo_wdata_i),
    .rdata(ro_rdata_o)
  );

endmodule

// File: doc/udma_l2_responder.md
Name: udma_l2_responder

Overview:
L2 memory responder for the uDMA core's two L2 master ports: the read-only TX port and the write-only RX port. It serves both ports from one byte-enabled single-port memory bank. Arbitration is round-robin, wait states are programmable, and the response valid comes one cycle after grant. It is used as the L2 endpoint in standalone uDMA subsystem benches and in small SoC integrations without a full L2 interconnect.

Parameters:
DATA_WIDTH, 32, L2 data width; must be 32 (matches L2_DATA_WIDTH).
MEM_WORDS, 4096, bank depth in words; power of two.
WAIT_CYCLES, 0, extra cycles a request must be held before grant; range 0..15.

Ports:
sys_clk_i  in  1  clock
rstn_i  in  1  synchronous active-low reset
ro_req_i  in  1  read port request
ro_wen_i  in  1  read port write-enable, high = read; ignored
ro_addr_i  in  32  read byte address
ro_be_i  in  DATA_WIDTH/8  ignored
ro_wdata_i  in  DATA_WIDTH  ignored
ro_gnt_o  out  1  read grant
ro_rvalid_o  out  1  read response valid
ro_rdata_o  out  DATA_WIDTH  read data
wo_req_i  in  1  write port request
wo_wen_i  in  1  write port write-enable, low = write; ignored
wo_addr_i  in  32  write byte address
wo_be_i  in  DATA_WIDTH/8  byte enables
wo_wdata_i  in  DATA_WIDTH  write data
wo_gnt_o  out  1  write grant
wo_rvalid_o  out  1  write ack valid
wo_rdata_o  out  DATA_WIDTH  always 0

Behaviour:
- Clock and reset: one clock, sys_clk_i. Reset rstn_i is synchronous, active-low.
- Reset values: gnt 0, rvalid 0, rdata 0, FSM IDLE, wait counter 0, last-served = WO (so RO wins the first tie). Memory contents are not reset.
- Port roles are fixed: the RO port always reads and the WO port always writes. The wen inputs are not decoded.
- Address mapping: word index = addr[$clog2(MEM_WORDS)+1:2]. Upper bits are ignored, so addresses alias modulo the bank size. addr[1:0] is ignored.
- Grant handshake: grant is a combinational, single-cycle pulse. It is only asserted while the corresponding req is high. At most one grant per cycle across both ports. The master must hold req, addr and data until it sees gnt.
- Winner selection: if only one req is high, that port wins. If both are high, the port not served last wins. The last-served flag updates on each grant.
- FSM:
  - IDLE: when any req is high, pick the winner.
    - WAIT_CYCLES = 0: grant that same cycle, stay in IDLE. Back-to-back grants are allowed every cycle.
    - WAIT_CYCLES > 0: latch the winner, load counter = WAIT_CYCLES, go to WAIT. No grant this cycle.
  - WAIT: decrement the counter each cycle.
    - Counter reaches 0 with the latched winner's req high: grant that cycle, return to IDLE.
    - Latched winner's req drops at any point in WAIT (protocol violation): return to IDLE with no grant and no access.
    - A req on the other port does not preempt the latched winner.
- Access: the memory operation happens in the grant cycle.
  - Write: only bytes with wo_be_i[k]=1 are updated.
  - Read: data is registered.
- Response latency:
  - ro_rvalid_o pulses exactly 1 cycle after ro_gnt_o, with ro_rdata_o valid in the same cycle. ro_rdata_o holds its value until the next read response.
  - wo_rvalid_o pulses 1 cycle after wo_gnt_o.
- Ordering: accesses take effect in grant order. A read granted the cycle after a write to the same word returns the new data. A WO write with be=0 is granted and acked but modifies nothing.
- Reset mid-operation: the WAIT state is abandoned, and any rvalid pending for the next cycle is suppressed (it stays 0).

Optional Feature:
UDMA_L2_RESP_STALL_EN
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - In any cycle where LFSR[0]=1, all grants are suppressed. In IDLE nothing is latched; in WAIT the counter holds at 0 until a non-stall cycle.
  - Used to stress uDMA req/gnt robustness.
- Undefined: no LFSR, no stalls, timing exactly as above.

Decomposition:
- Package udma_l2_resp_pkg:
  - enum l2_resp_state_e {IDLE, WAIT}
  - enum l2_resp_port_e {PORT_RO, PORT_WO}
  - LFSR_SEED and LFSR tap constants
- Sub-module udma_l2_resp_bank: single-port, MEM_WORDS x DATA_WIDTH, byte-enable write, 1-cycle registered read.
- The top level contains the arbiter, FSM, response pipeline and optional LFSR.

Test Plan:
- WAIT_CYCLES=0, WO write addr 0x100, data 0xDEADBEEF, be 4'hF; then RO read 0x100 -> wo_gnt the same cycle as req; ro_rvalid 1 cycle after ro_gnt with rdata 0xDEADBEEF.
- Partial write to 0x100 of 0x000000AA with be 4'b0001 over 0xDEADBEEF, then read -> 0xDEADBEAA; write 0x200 with be 4'b0000 -> acked, contents unchanged.
- Both req high continuously for 6 cycles, WAIT_CYCLES=0 -> grants alternate RO, WO, RO, WO, RO, WO; each rvalid follows its grant by exactly 1 cycle.
- WAIT_CYCLES=3, RO req held -> gnt in the 4th cycle of req; if req drops in cycle 2 -> no gnt, no rvalid, FSM back to IDLE.
- Aliasing with MEM_WORDS=4096: write 0x12345678 to 0x0000_4004, read 0x0000_0004 -> 0x12345678.
- Assert rstn_i low the cycle after a grant -> no rvalid the next cycle; all outputs 0. With UDMA_L2_RESP_STALL_EN defined, 1000 random requests: all granted and acked, no data mismatches.
